max7219_refresh_ctrl: RTL and testbench

Sequencer that owns a daisy-chain of MAX7219 8x8 LED drivers through the spi_max7219 transmitter. After reset it runs the MAX7219 init command sequence, then repeatedly sends intensity and eight row commands from an internal frame buffer, with a programmable idle gap between frames. Upstream logic draws into the frame buffer through a byte-wide write port and never touches SPI timing.

---
 rtl/max7219_refresh_ctrl.sv | 171 +++++++++++++++++
 tb/tb_max7219_refresh_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/max7219_refresh_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : max7219_refresh_ctrl
// Description : Drives a MAX7219 daisy-chain through spi_max7219: init
//               sequence, then intensity + 8 rows from a frame buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module max7219_refresh_ctrl #(
  parameter int NUM_DEVICES   = 20,
  parameter int REFRESH_DELAY = 4000000,
  parameter int DATA_WIDTH    = NUM_DEVICES * 16
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst_n,
  input  logic                           i_Wr_En,
  input  logic [$clog2(NUM_DEVICES)-1:0] i_Wr_Dev,
  input  logic [2:0]                     i_Wr_Row,
  input  logic [7:0]                     i_Wr_Data,
  input  logic [3:0]                     i_Intensity,
  input  logic                           i_Reinit,
  input  logic                           i_SPI_Busy,
  output logic                           o_Data_Valid,
  output logic [DATA_WIDTH-1:0]          o_Data,
  output logic                           o_Frame_Done
);

  localparam int DEV_W = $clog2(NUM_DEVICES);
  localparam int CNT_W = (REFRESH_DELAY < 2) ? 1 : $clog2(REFRESH_DELAY + 1);

  localparam logic [3:0] c_SHUT      = 4'd0;
  localparam logic [3:0] c_DECODE    = 4'd1;
  localparam logic [3:0] c_SCAN      = 4'd2;
  localparam logic [3:0] c_TEST      = 4'd3;
  localparam logic [3:0] c_NORMAL    = 4'd4;
  localparam logic [3:0] c_INTENSITY = 4'd5;
  localparam logic [3:0] c_ROW0      = 4'd6;
  localparam logic [3:0] c_ROW7      = 4'd13;

  typedef enum logic [1:0] {
    ST_ISSUE     = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_DELAY     = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cmd_q, cmd_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    pending_q, pending_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [7:0]              fb_q [NUM_DEVICES][8];

  logic [DATA_WIDTH-1:0]   w_cmd_data;
  logic [2:0]              w_row;
  logic [3:0]              w_row_reg;
  logic                    w_clr_pending;

  assign w_row     = 3'(cmd_q - c_ROW0);
  assign w_row_reg = {1'b0, w_row} + 4'd1;

  // Out-of-range device indices never match any d, so those writes drop out.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int d = 0; d < NUM_DEVICES; d++)
        for (int r = 0; r < 8; r++)
          fb_q[d][r] <= '0;
    end else if (i_Wr_En) begin
      for (int d = 0; d < NUM_DEVICES; d++)
        if (i_Wr_Dev == DEV_W'(d))
          fb_q[d][i_Wr_Row] <= i_Wr_Data;
    end
  end

  always_comb begin
    w_cmd_data = '0;
    for (int d = 0; d < NUM_DEVICES; d++) begin
      case (cmd_q)
        c_SHUT:      w_cmd_data[16*d +: 16] = 16'h0C00;
        c_DECODE:    w_cmd_data[16*d +: 16] = 16'h0900;
        c_SCAN:      w_cmd_data[16*d +: 16] = 16'h0B07;
        c_TEST:      w_cmd_data[16*d +: 16] = 16'h0F00;
        c_NORMAL:    w_cmd_data[16*d +: 16] = 16'h0C01;
        c_INTENSITY: w_cmd_data[16*d +: 16] = {12'h0A0, i_Intensity};
        default:     w_cmd_data[16*d +: 16] = {4'h0, w_row_reg, fb_q[d][w_row]};
      endcase
    end
  end

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    valid_d       = 1'b0;
    done_d        = 1'b0;
    w_clr_pending = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        if (pending_q) begin
          cmd_d         = c_SHUT;
          w_clr_pending = 1'b1;
        end else if (!i_SPI_Busy) begin
          data_d  = w_cmd_data;
          valid_d = 1'b1;
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (i_SPI_Busy) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!i_SPI_Busy) begin
          state_d = ST_ISSUE;
          if (cmd_q == c_ROW7) begin
            done_d = 1'b1;
            cmd_d  = c_INTENSITY;
            if (REFRESH_DELAY != 0) begin
              state_d = ST_DELAY;
              cnt_d   = CNT_W'(REFRESH_DELAY);
            end
          end else begin
            cmd_d = cmd_q + 4'd1;
          end
        end
      end
      ST_DELAY: begin
        if (pending_q) begin
          state_d       = ST_ISSUE;
          cmd_d         = c_SHUT;
          w_clr_pending = 1'b1;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_ISSUE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_ISSUE;
    endcase
    // A request arriving on the clearing cycle must survive.
    pending_d = (pending_q & ~w_clr_pending) | i_Reinit;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= ST_ISSUE;
      cmd_q     <= c_SHUT;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      data_q    <= data_d;
    end
  end

  assign o_Data_Valid = valid_q;
  assign o_Data       = data_q;
  assign o_Frame_Done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_max7219_refresh_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_max7219_refresh_ctrl
// Description : Directed bench for max7219_refresh_ctrl with an SPI busy model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_max7219_refresh_ctrl;

  localparam int ND = 20;
  localparam int DW = ND * 16;
  localparam int RD = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [4:0]    wr_dev = '0;
  logic [2:0]    wr_row = '0;
  logic [7:0]    wr_data = '0;
  logic [3:0]    intensity = 4'd9;
  logic          reinit = 1'b0;
  logic          force_busy = 1'b0;
  logic          bm_busy = 1'b0;
  logic          spi_busy;
  logic          valid;
  logic [DW-1:0] data;
  logic          frame_done;

  int checks = 0;
  int failures = 0;
  int bm_wait = 0;
  int bm_hold = 0;
  logic [7:0] fb_m [ND][8];

  assign spi_busy = force_busy | bm_busy;

  max7219_refresh_ctrl #(.NUM_DEVICES(ND), .REFRESH_DELAY(RD)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Wr_En(wr_en), .i_Wr_Dev(wr_dev),
    .i_Wr_Row(wr_row), .i_Wr_Data(wr_data), .i_Intensity(intensity),
    .i_Reinit(reinit), .i_SPI_Busy(spi_busy), .o_Data_Valid(valid),
    .o_Data(data), .o_Frame_Done(frame_done)
  );

  always #5 clk = ~clk;

  // SPI model: busy rises 2 cycles after a valid pulse and stays high 10 cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      bm_wait = 0; bm_hold = 0; bm_busy = 1'b0;
    end else if (bm_hold > 0) begin
      bm_hold--;
      if (bm_hold == 0) bm_busy = 1'b0;
    end else if (bm_wait > 0) begin
      bm_wait--;
      if (bm_wait == 0) begin bm_busy = 1'b1; bm_hold = 10; end
    end else if (valid) begin
      bm_wait = 2;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_pulse(input string tag, output logic [DW-1:0] d, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!valid && n < 2000);
    check({tag, "_seen"}, DW'(valid), DW'(1'b1));
    d = data;
  endtask

  function automatic logic [DW-1:0] rep(input logic [15:0] w);
    logic [DW-1:0] v;
    for (int d = 0; d < ND; d++) v[16*d +: 16] = w;
    return v;
  endfunction

  function automatic logic [DW-1:0] exp_row(input int r);
    logic [DW-1:0] v;
    for (int d = 0; d < ND; d++) v[16*d +: 16] = {4'h0, 4'(r + 1), fb_m[d][r]};
    return v;
  endfunction

  initial begin
    logic [DW-1:0] got;
    logic [15:0]   init_w [5];
    int            n;
    init_w[0] = 16'h0C00; init_w[1] = 16'h0900; init_w[2] = 16'h0B07;
    init_w[3] = 16'h0F00; init_w[4] = 16'h0C01;
    for (int d = 0; d < ND; d++) for (int r = 0; r < 8; r++) fb_m[d][r] = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_valid", DW'(valid), '0);
    check("rst_data", data, '0);
    check("rst_done", DW'(frame_done), '0);

    rst_n = 1'b1;
    wait_pulse("init0", got, n);
    check("first_pulse_latency", DW'(n), DW'(1));
    check("init0_word", got, rep(init_w[0]));
    @(negedge clk);
    check("valid_one_cycle", DW'(valid), '0);
    wr_en = 1'b1; wr_dev = 5'd3; wr_row = 3'd5; wr_data = 8'hA5;
    fb_m[3][5] = 8'hA5;
    @(negedge clk);
    wr_dev = 5'd25; wr_row = 3'd0; wr_data = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    for (int i = 1; i < 5; i++) begin
      wait_pulse("init", got, n);
      check($sformatf("init%0d_word", i), got, rep(init_w[i]));
    end

    wait_pulse("int1", got, n);
    check("intensity9", got, rep(16'h0A09));
    for (int r = 0; r < 2; r++) begin
      wait_pulse("row", got, n);
      check($sformatf("f1_row%0d", r), got, exp_row(r));
    end
    // Place a row-2 write on the edge that loads the ROW2 command.
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!spi_busy && n < 100);
    do begin @(negedge clk); #1; n++; end while (spi_busy && n < 200);
    @(negedge clk);
    wr_en = 1'b1; wr_dev = 5'd7; wr_row = 3'd2; wr_data = 8'h3C;
    @(negedge clk);
    wr_en = 1'b0;
    check("row2_load_edge", DW'(valid), DW'(1'b1));
    check("f1_row2_old", data, exp_row(2));
    fb_m[7][2] = 8'h3C;
    for (int r = 3; r < 8; r++) begin
      wait_pulse("row", got, n);
      check($sformatf("f1_row%0d", r), got, exp_row(r));
    end

    n = 0;
    do begin @(negedge clk); n++; end while (!frame_done && n < 100);
    check("frame_done_seen", DW'(frame_done), DW'(1'b1));
    intensity = 4'd3;
    n = 0;
    begin : gap_count
      for (int k = 0; k < 1000; k++) begin
        @(negedge clk);
        if (valid) disable gap_count;
        n++;
      end
    end
    check("idle_gap", DW'(n), DW'(RD));
    check("intensity3", data, rep(16'h0A03));

    for (int r = 0; r < 4; r++) begin
      wait_pulse("row", got, n);
      check($sformatf("f2_row%0d", r), got, exp_row(r));
    end
    @(negedge clk);
    reinit = 1'b1;
    @(negedge clk);
    reinit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_pulse("reinit", got, n);
      check($sformatf("reinit%0d_word", i), got, rep(init_w[i]));
    end
    wait_pulse("int2", got, n);
    check("reinit_intensity", got, rep(16'h0A03));

    force_busy = 1'b1;
    n = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (valid) n++;
    end
    check("busy_hold_no_pulse", DW'(n), '0);
    force_busy = 1'b0;
    wait_pulse("hold_row0", got, n);
    check("after_hold_row0", got, exp_row(0));

    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", DW'(valid), '0);
    check("async_rst_data", data, '0);
    check("async_rst_done", DW'(frame_done), '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_pulse("post_rst", got, n);
    check("post_rst_shut", got, rep(16'h0C00));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
